// File: rtl/cmd_pkg.sv
// Shared types and constants for the 24-bit command sender and its UART byte transmitter.
package cmd_pkg;

  localparam int unsigned CMD_W            = 24;
  localparam int unsigned BYTE_W           = 8;
  localparam int unsigned FRAME_W          = 10;
  localparam int unsigned BAUD_CNT_W       = 12;
  localparam int unsigned BIT_CNT_W        = 4;
  localparam int unsigned BYTE_IDX_W       = 2;
  localparam int unsigned BAUD_DIV_DEFAULT = 2604;

  typedef enum logic {
    CMD_IDLE,
    CMD_SEND
  } cmd_state_e;

  typedef enum logic {
    TX_IDLE,
    TX_TRANSMIT
  } tx_state_e;

  // Byte 0 is the most significant byte of the command word.
  function automatic logic [BYTE_W-1:0] get_byte(input logic [CMD_W-1:0] word,
                                                 input logic [BYTE_IDX_W-1:0] idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = word[23:16];
      2'd1:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART byte transmitter: 8N1 frame, one bit per BAUD_DIV clocks, reloadable in the last stop-bit clock.
module uart_tx
  import cmd_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trmt,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              TX,
  output logic              tx_done
);

  localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(BAUD_DIV - 1);
  localparam logic [BAUD_CNT_W-1:0] BAUD_PRE  = BAUD_CNT_W'(BAUD_DIV - 2);
  localparam logic [BIT_CNT_W-1:0]  BIT_STOP  = BIT_CNT_W'(FRAME_W - 1);

  tx_state_e               state_q, state_d;
  logic [FRAME_W-1:0]      shift_q, shift_d;
  logic [BAUD_CNT_W-1:0]   baud_q, baud_d;
  logic [BIT_CNT_W-1:0]    bit_q, bit_d;
  logic                    done_q, done_d;

  // Next-state: a trmt always (re)loads the frame, otherwise shift one bit per baud period.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    if (trmt) begin
      state_d = TX_TRANSMIT;
      shift_d = {1'b1, tx_data, 1'b0};
      baud_d  = '0;
      bit_d   = '0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          baud_d = '0;
          bit_d  = '0;
        end
        TX_TRANSMIT: begin
          // Registered done flag lands exactly on the last clock of the stop bit.
          done_d = (bit_q == BIT_STOP) && (baud_q == BAUD_PRE);
          if (baud_q == BAUD_LAST) begin
            baud_d  = '0;
            shift_d = {1'b1, shift_q[FRAME_W-1:1]};
            bit_d   = bit_q + BIT_CNT_W'(1);
            if (bit_q == BIT_STOP) begin
              state_d = TX_IDLE;
            end
          end else begin
            baud_d = baud_q + BAUD_CNT_W'(1);
          end
        end
        default: state_d = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      shift_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
    end
  end

  assign TX      = shift_q[0];
  assign tx_done = done_q;

endmodule

// File: rtl/cmd_sender.sv
// Serializes a 24-bit command as three back-to-back UART frames, MSB byte first.
module cmd_sender
  import cmd_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             snd_cmd,
  input  logic [CMD_W-1:0] cmd,
  output logic             TX,
  output logic             busy,
  output logic             cmd_cmplt
);

  cmd_state_e              state_q, state_d;
  logic [BYTE_IDX_W-1:0]   k_q, k_d;
  logic                    busy_q, busy_d;
  logic                    cmplt_q, cmplt_d;
  logic                    start_q, start_d;
  logic [CMD_W-1:0]        hold_q, hold_d;
  logic                    trmt_c;
  logic [BYTE_IDX_W-1:0]   byte_idx_c;
  logic [BYTE_W-1:0]       tx_data_c;
  logic                    tx_done;

  // Byte k+1 is launched in the same cycle as tx_done for byte k so frames abut.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    busy_d     = busy_q;
    cmplt_d    = cmplt_q;
    start_d    = 1'b0;
    hold_d     = hold_q;
    trmt_c     = 1'b0;
    byte_idx_c = k_q;
    case (state_q)
      CMD_IDLE: begin
        if (snd_cmd) begin
          state_d = CMD_SEND;
          k_d     = '0;
          busy_d  = 1'b1;
          cmplt_d = 1'b0;
          start_d = 1'b1;
          hold_d  = cmd;
        end
      end
      CMD_SEND: begin
        if (start_q) begin
          trmt_c     = 1'b1;
          byte_idx_c = '0;
        end else if (tx_done) begin
          if (k_q < BYTE_IDX_W'(2)) begin
            k_d        = k_q + BYTE_IDX_W'(1);
            trmt_c     = 1'b1;
            byte_idx_c = k_q + BYTE_IDX_W'(1);
          end else begin
            state_d = CMD_IDLE;
            busy_d  = 1'b0;
            cmplt_d = 1'b1;
          end
        end
      end
      default: state_d = CMD_IDLE;
    endcase
  end

  assign tx_data_c = get_byte(hold_q, byte_idx_c);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CMD_IDLE;
      k_q     <= '0;
      busy_q  <= 1'b0;
      cmplt_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      cmplt_q <= cmplt_d;
      start_q <= start_d;
    end
  end

  // Holding register carries no reset; it is only read while a command is in flight.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  uart_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt_c),
    .tx_data (tx_data_c),
    .TX      (TX),
    .tx_done (tx_done)
  );

  assign busy      = busy_q;
  assign cmd_cmplt = cmplt_q;

endmodule

// File: tb/tb_cmd_sender.sv
// Directed bench for cmd_sender with BAUD_DIV=16: framing, latency, ignore rules and reset abort.
module tb_cmd_sender;

  localparam int unsigned BD = 16;

  logic        clk;
  logic        rst_n;
  logic        snd_cmd;
  logic [23:0] cmd;
  logic        tx;
  logic        busy;
  logic        cmd_cmplt;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  cmd_sender #(.BAUD_DIV(BD)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .snd_cmd   (snd_cmd),
    .cmd       (cmd),
    .TX        (tx),
    .busy      (busy),
    .cmd_cmplt (cmd_cmplt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at 1 time unit after the edge that makes TX go low; returns at the next frame start.
  task automatic rx_frame(input string tag, input logic [7:0] exp_byte, output logic [9:0] bits);
    logic stable;
    logic v;
    stable = 1'b1;
    bits   = '0;
    for (int i = 0; i < 10; i++) begin
      v = tx;
      for (int c = 0; c < int'(BD); c++) begin
        if (tx !== v) stable = 1'b0;
        if (c == int'(BD / 2)) bits[i] = tx;
        tick();
      end
    end
    check({tag, "_start"}, 32'(bits[0]), 32'h0);
    check({tag, "_stop"},  32'(bits[9]), 32'h1);
    check({tag, "_data"},  32'(bits[8:1]), 32'(exp_byte));
    check({tag, "_hold"},  32'(stable), 32'h1);
  endtask

  // Pulses snd_cmd for one cycle; returns 1 unit after the accepting edge.
  task automatic send(input logic [23:0] c);
    cmd     = c;
    snd_cmd = 1'b1;
    tick();
    snd_cmd = 1'b0;
  endtask

  initial begin
    logic [9:0] bits;
    logic ok_tx, ok_busy, ok_cmplt;

    rst_n   = 1'b0;
    snd_cmd = 1'b0;
    cmd     = '0;
    tick();
    tick();
    check("rst_tx",    32'(tx), 32'h1);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_cmplt", 32'(cmd_cmplt), 32'h0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Basic send with an ignored request and a mid-flight cmd change.
    send(24'hA53C0F);
    check("acc_busy", 32'(busy), 32'h1);
    check("acc_tx",   32'(tx), 32'h1);
    tick();
    check("lat_tx", 32'(tx), 32'h0);
    fork
      begin
        rx_frame("t1_b0", 8'hA5, bits);
        rx_frame("t1_b1", 8'h3C, bits);
        rx_frame("t1_b2", 8'h0F, bits);
      end
      begin
        repeat (98) tick();
        cmd     = 24'h123456;
        snd_cmd = 1'b1;
        tick();
        snd_cmd = 1'b0;
        cmd     = 24'hDEADBE;
        check("ign_busy", 32'(busy), 32'h1);
      end
    join
    check("t1_cmplt", 32'(cmd_cmplt), 32'h1);
    check("t1_busy",  32'(busy), 32'h0);
    check("t1_idle",  32'(tx), 32'h1);
    repeat (20) tick();
    check("t1_sticky", 32'(cmd_cmplt), 32'h1);
    check("t1_quiet",  32'(tx), 32'h1);

    // All-zero and all-one payloads.
    send(24'h000000);
    check("z_clr", 32'(cmd_cmplt), 32'h0);
    tick();
    for (int b = 0; b < 3; b++) begin
      rx_frame("zero", 8'h00, bits);
      check("zero_frame", 32'(bits), 32'h200);
    end
    check("z_cmplt", 32'(cmd_cmplt), 32'h1);
    send(24'hFFFFFF);
    check("f_clr", 32'(cmd_cmplt), 32'h0);
    tick();
    for (int b = 0; b < 3; b++) begin
      rx_frame("ones", 8'hFF, bits);
      check("ones_frame", 32'(bits), 32'h3FE);
    end
    check("f_cmplt", 32'(cmd_cmplt), 32'h1);

    // Request in the final stop-bit cycle is ignored, one cycle later is accepted.
    send(24'h5A0011);
    tick();
    rx_frame("t3_b0", 8'h5A, bits);
    rx_frame("t3_b1", 8'h00, bits);
    repeat (159) tick();
    check("last_busy",  32'(busy), 32'h1);
    check("last_cmplt", 32'(cmd_cmplt), 32'h0);
    cmd     = 24'h777777;
    snd_cmd = 1'b1;
    tick();
    check("late_busy",  32'(busy), 32'h0);
    check("late_cmplt", 32'(cmd_cmplt), 32'h1);
    check("late_tx",    32'(tx), 32'h1);
    cmd = 24'h8142C3;
    tick();
    snd_cmd = 1'b0;
    check("re_busy",  32'(busy), 32'h1);
    check("re_cmplt", 32'(cmd_cmplt), 32'h0);
    check("re_tx",    32'(tx), 32'h1);
    tick();
    check("re_lat", 32'(tx), 32'h0);
    rx_frame("t4_b0", 8'h81, bits);
    rx_frame("t4_b1", 8'h42, bits);
    rx_frame("t4_b2", 8'hC3, bits);
    check("t4_cmplt", 32'(cmd_cmplt), 32'h1);

    // Reset mid-transmission aborts with no completion.
    send(24'hA53C0F);
    tick();
    repeat (199) tick();
    rst_n = 1'b0;
    tick();
    check("abort_tx",    32'(tx), 32'h1);
    check("abort_busy",  32'(busy), 32'h0);
    check("abort_cmplt", 32'(cmd_cmplt), 32'h0);
    rst_n    = 1'b1;
    ok_tx    = 1'b1;
    ok_busy  = 1'b1;
    ok_cmplt = 1'b1;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (tx !== 1'b1) ok_tx = 1'b0;
      if (busy !== 1'b0) ok_busy = 1'b0;
      if (cmd_cmplt !== 1'b0) ok_cmplt = 1'b0;
    end
    check("post_tx",    32'(ok_tx), 32'h1);
    check("post_busy",  32'(ok_busy), 32'h1);
    check("post_cmplt", 32'(ok_cmplt), 32'h1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/cmd_sender.md
CMD_SENDER -- requirements
Module: cmd_sender

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 2604, meaning clocks per UART bit period (legal range 4..4095).
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port snd_cmd, input, 1, request to send cmd; a single-cycle pulse is sufficient.
REQ-005 SHALL have port cmd, input, 24, the command word to serialize.
REQ-006 SHALL have port TX, output, 1, the UART serial line, idle high.
REQ-007 SHALL have port busy, output, 1, high while a command is being transmitted.
REQ-008 SHALL have port cmd_cmplt, output, 1, sticky flag set when all 3 bytes have been sent.

Function
REQ-009 SHALL accept snd_cmd only when busy=0; snd_cmd while busy=1 SHALL be ignored, with no effect on the frame in flight.
REQ-010 SHALL capture cmd into an internal 24-bit holding register on the accepting edge; later changes on cmd SHALL have no effect until the next acceptance.
REQ-011 SHALL send the bytes in the order cmd[23:16], cmd[15:8], cmd[7:0].
REQ-012 SHALL send each byte as a 10-bit frame: start bit 0, data bits LSB first, stop bit 1.
REQ-013 SHALL hold each bit on TX for exactly BAUD_DIV clocks.
REQ-014 SHALL drive TX low starting in the cycle after the accepting edge, i.e. 1-cycle latency.
REQ-015 SHALL send frames back-to-back, each start bit immediately following the previous stop bit, with no idle cycles; a total transmission SHALL last exactly 30*BAUD_DIV cycles.
REQ-016 SHALL implement the top FSM with states IDLE, SEND (byte k in flight, k=0..2 held in a 2-bit byte counter) and DONE-transition handling:
  - IDLE->SEND on snd_cmd, which issues the internal trmt for byte 0.
  - In SEND, each internal tx_done with k<2 SHALL increment k and issue trmt in the same cycle.
  - tx_done with k=2 SHALL return the FSM to IDLE.
REQ-017 SHALL raise busy on the accepting edge and clear it on the edge where the final tx_done is sampled.
REQ-018 SHALL set cmd_cmplt on the edge where the final tx_done is sampled, so it rises in the same cycle TX returns to idle high.
REQ-019 SHALL hold cmd_cmplt until the next accepted snd_cmd, which clears it on the accepting edge, or until reset.
REQ-020 SHALL ignore a snd_cmd arriving in the final stop-bit cycle, because busy=1 in that cycle.
REQ-021 SHALL, in the byte transmitter, use:
  - a 10-bit shift register loaded {1,data,0} on trmt;
  - a baud counter that shifts when it reaches BAUD_DIV-1 and then wraps to 0;
  - a 4-bit bit counter 0..10.
REQ-022 SHALL pulse tx_done for exactly one cycle, during the last clock of the stop bit.
REQ-023 SHALL, in the byte transmitter, hold TX high when idle; shifting SHALL shift in 1s.

Reset
REQ-024 SHALL, while rst_n=0 at a clk edge, set: FSM=IDLE, byte counter=0, baud counter=0, bit counter=0, shift register=all 1s.
REQ-025 SHALL have reset values TX=1, busy=0, cmd_cmplt=0.
REQ-026 SHALL abort a transmission immediately on a reset asserted mid-transmission: TX=1 from the next edge and no cmd_cmplt pulse.
REQ-027 SHALL leave the holding register contents unspecified after reset; the holding register SHALL NOT be observable.

Structure
REQ-028 SHALL place in shared package cmd_pkg: the top FSM state enum, the byte-transmitter state enum (IDLE, TRANSMIT), CMD_W=24 and the default BAUD_DIV constant.
REQ-029 SHALL instantiate exactly one sub-module, uart_tx, with ports clk, rst_n, trmt, tx_data[7:0], TX, tx_done and parameter BAUD_DIV.

Verification (bench BAUD_DIV=16)
REQ-030 SHALL cover: cmd=24'hA5_3C_0F, pulse snd_cmd at edge N -> TX low from N+1; sampled bytes 8'hA5, 8'h3C, 8'h0F; cmd_cmplt=1 and busy=0 at N+1+480.
REQ-031 SHALL cover: cmd=24'h000000 then 24'hFFFFFF -> each data bit holds 16 cycles and framing is correct; the 8'hFF frame shows only the start bit low.
REQ-032 SHALL cover: second snd_cmd with cmd=24'h123456 at N+100 -> ignored; the line still carries A5/3C/0F.
REQ-033 SHALL cover: rst_n=0 for 1 cycle at N+200 -> TX=1, busy=0, cmd_cmplt=0 from N+201; no frame resumes.
REQ-034 SHALL cover: snd_cmd in the final stop-bit cycle -> ignored; a snd_cmd one cycle later -> accepted, cmd_cmplt clears, TX low the next cycle.
REQ-035 SHALL cover: cmd changed to 24'hDEADBE during transmission -> transmitted bytes unchanged.
